// File: rtl/sa_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : sa_result_collector
// Purpose  : Collects the element stream emitted by the 4x4 systolic array
//            (shift_out while ack is high) into a two-frame ping-pong buffer
//            and streams each complete N*N frame row-major to the host over a
//            valid/ready port. start_ok tells the array controller when it
//            may launch a new computation.
// Ports    : clk, rst (async, active-high)
//            in_valid / in_data      element stream from the array
//            start_ok                free frame available, writer idle
//            out_valid / out_ready / out_data / out_last   host stream
//            overflow / clr_overflow sticky dropped-frame flag and its clear
// Revision : 1.0  initial release
// ============================================================================
module sa_result_collector #(
  parameter int DATA_W = 8,
  parameter int N      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              start_ok,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam int DEPTH = N * N;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_DROP = 2'd2
  } wstate_e;

  wstate_e           state_q, state_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic              wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  logic              overflow_q, overflow_d;

  logic              wr_en;
  logic              ovf_set;
  logic [1:0]        full_set;
  logic [1:0]        full_clr;
  logic              rd_fire;

  logic [DATA_W-1:0] mem_q [2][DEPTH];

  // Write side: full_q is sampled before this cycle's read-side clear, so a
  // bank freed at this edge is only visible to the next element.
  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    wr_en     = 1'b0;
    ovf_set   = 1'b0;
    full_set  = 2'b00;
    case (state_q)
      W_IDLE: begin
        if (in_valid) begin
          wr_idx_d = IDX_W'(1);
          if (!full_q[wr_bank_q]) begin
            wr_en   = 1'b1;
            state_d = W_FILL;
          end else begin
            ovf_set = 1'b1;
            state_d = W_DROP;
          end
        end
      end
      W_FILL: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            full_set[wr_bank_q] = 1'b1;
            wr_bank_d           = ~wr_bank_q;
            wr_idx_d            = '0;
            state_d             = W_IDLE;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      W_DROP: begin
        // A dropped frame is always discarded to its end, even if a bank
        // becomes free partway through, so frames never get misaligned.
        if (in_valid) begin
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d = '0;
            state_d  = W_IDLE;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d  = W_IDLE;
        wr_idx_d = '0;
      end
    endcase
  end

  // Read side
  always_comb begin
    rd_idx_d  = rd_idx_q;
    rd_bank_d = rd_bank_q;
    full_clr  = 2'b00;
    rd_fire   = full_q[rd_bank_q] & out_ready;
    if (rd_fire) begin
      if (rd_idx_q == LAST_IDX) begin
        full_clr[rd_bank_q] = 1'b1;
        rd_bank_d           = ~rd_bank_q;
        rd_idx_d            = '0;
      end else begin
        rd_idx_d = rd_idx_q + IDX_W'(1);
      end
    end
  end

  // Commit always targets a non-full bank and the read clears a full one,
  // so set and clear never address the same bank in one cycle.
  assign full_d     = (full_q & ~full_clr) | full_set;
  assign overflow_d = ovf_set | (overflow_q & ~clr_overflow);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= W_IDLE;
      wr_idx_q   <= '0;
      wr_bank_q  <= 1'b0;
      rd_idx_q   <= '0;
      rd_bank_q  <= 1'b0;
      full_q     <= 2'b00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      wr_bank_q  <= wr_bank_d;
      rd_idx_q   <= rd_idx_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  // Frame storage needs no reset: contents are only visible through full_q.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_bank_q][wr_idx_q] <= in_data;
    end
  end

  assign out_valid = full_q[rd_bank_q];
  assign out_data  = out_valid ? mem_q[rd_bank_q][rd_idx_q] : '0;
  assign out_last  = out_valid & (rd_idx_q == LAST_IDX);
  assign start_ok  = (state_q == W_IDLE) & ~full_q[wr_bank_q];
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sa_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa_result_collector
// Purpose  : Directed self-checking bench for sa_result_collector.
// Revision : 1.0  initial release
// ============================================================================
module tb_sa_result_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       start_ok;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       overflow;
  logic       clr_overflow;

  sa_result_collector #(.DATA_W(8), .N(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .start_ok     (start_ok),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  int         tests  = 0;
  int         fails  = 0;
  int         rd_cnt = 0;
  logic [7:0] exp_q[$];
  logic       hold_q = 1'b0;
  logic [7:0] hold_d = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle without scoreboard checks.
  task automatic drive(input logic v, input logic [7:0] d, input logic rdy);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    @(posedge clk); #1;
  endtask

  // Check current outputs against the expected stream, apply inputs, advance.
  task automatic cyc(input logic v, input logic [7:0] d, input logic rdy);
    if (hold_q) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_data", {24'd0, out_data}, {24'd0, hold_d});
    end
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        chk("data", {24'd0, out_data}, {24'd0, exp_q[0]});
        chk("last", {31'd0, out_last}, {31'd0, (rd_cnt % 16) == 15});
      end
    end else begin
      chk("idle_data", {24'd0, out_data}, 32'd0);
      chk("idle_last", {31'd0, out_last}, 32'd0);
    end
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    hold_q    = out_valid && !rdy;
    hold_d    = out_data;
    if (out_valid && rdy && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      rd_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) cyc(1'b0, 8'd0, 1'b1);
    chk("drain_empty", exp_q.size(), 32'd0);
    chk("drain_idle", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_start_ok", {31'd0, start_ok}, 32'd1);
    rst = 1'b0;

    // 1: one unread frame plus a partial frame, then reset mid-stream
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i + 1), 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(50 + i), 1'b0);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_start_ok", {31'd0, start_ok}, 32'd0);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, out_data}, 32'd0);
    chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    chk("mid_rst_start_ok", {31'd0, start_ok}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // 2: single frame, host always ready
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i + 1));
      cyc(1'b1, 8'(i + 1), 1'b1);
      if (i < 15) begin
        chk("t2_filling_start_ok", {31'd0, start_ok}, 32'd0);
        chk("t2_early_valid", {31'd0, out_valid}, 32'd0);
      end
    end
    chk("t2_latency", {31'd0, out_valid}, 32'd1);
    chk("t2_first", {24'd0, out_data}, 32'd1);
    drain();
    chk("t2_start_ok", {31'd0, start_ok}, 32'd1);

    // 3: input gaps and sparse out_ready
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i + 1));
    begin
      int k = 0;
      for (int c = 0; c < 200 && (exp_q.size() > 0 || k < 16); c++) begin
        logic v;
        v = (c % 2 == 0) && (k < 16);
        cyc(v, v ? 8'(k + 1) : 8'd0, (c % 3) == 2);
        if (v) k++;
      end
    end
    chk("t3_drained", exp_q.size(), 32'd0);

    // 4: ping-pong, both frames held then read back to back
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i + 1));
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(101 + i));
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i + 1), 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(101 + i), 1'b0);
    chk("t4_start_ok_full", {31'd0, start_ok}, 32'd0);
    chk("t4_no_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      chk("t4_no_bubble", {31'd0, out_valid}, 32'd1);
      cyc(1'b0, 8'd0, 1'b1);
    end
    chk("t4_idle", {31'd0, out_valid}, 32'd0);
    chk("t4_start_ok", {31'd0, start_ok}, 32'd1);

    // 5: overflow; a bank frees mid-drop and the drop still completes
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i + 1));
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(101 + i));
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i + 1), 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(101 + i), 1'b0);
    for (int c = 0; c < 32; c++) begin
      cyc((c % 2) == 0, 8'(200 + c / 2), 1'b1);
      if (c == 0) chk("t5_ovf_set", {31'd0, overflow}, 32'd1);
      if (c == 20) chk("t5_drop_start_ok", {31'd0, start_ok}, 32'd0);
    end
    chk("t5_after_drop_start_ok", {31'd0, start_ok}, 32'd1);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(50 + i));
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(50 + i), 1'b0);
    drain();
    chk("t5_ovf_sticky", {31'd0, overflow}, 32'd1);
    clr_overflow = 1'b1;
    cyc(1'b0, 8'd0, 1'b0);
    clr_overflow = 1'b0;
    chk("t5_ovf_clr", {31'd0, overflow}, 32'd0);

    // 5b: set and clear in the same cycle, set wins
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(10 + i));
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(30 + i));
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(10 + i), 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(30 + i), 1'b0);
    clr_overflow = 1'b1;
    cyc(1'b1, 8'hEE, 1'b0);
    clr_overflow = 1'b0;
    chk("t5b_set_wins", {31'd0, overflow}, 32'd1);
    for (int i = 1; i < 16; i++) cyc(1'b1, 8'hEE, 1'b0);
    drain();

    // 6: commit and last read on the same edge
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(71 + i));
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(91 + i));
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(71 + i), 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(91 + i), 1'b1);
    chk("t6_valid", {31'd0, out_valid}, 32'd1);
    chk("t6_data", {24'd0, out_data}, 32'd91);
    chk("t6_start_ok", {31'd0, start_ok}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("t6_no_bubble", {31'd0, out_valid}, 32'd1);
      cyc(1'b0, 8'd0, 1'b1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
